ws_sta_ctrl: RTL

WS_STA_CTRL -- requirements
Module: ws_sta_ctrl

---
 rtl/ws_sta_ctrl_if.sv | 23 ++
 rtl/ws_sta_ctrl.sv | 120 ++++++++++++
 2 files changed

// File: rtl/ws_sta_ctrl_if.sv
// Handshake and array-control bundle between the weight-stationary sequencer and its neighbours.
// master = upstream/array side (drives b_valid/a_valid), slave = the sequencer.
interface ws_sta_ctrl_if;
    logic        b_valid;
    logic        b_ready;
    logic        a_valid;
    logic        a_ready;
    logic        array_propagate_b;
    logic        array_a_en;
    logic        array_zero_in;
    logic        c_valid;
    logic [15:0] c_index;

    modport master (
        output b_valid, a_valid,
        input  b_ready, a_ready, array_propagate_b, array_a_en, array_zero_in, c_valid, c_index
    );

    modport slave (
        input  b_valid, a_valid,
        output b_ready, a_ready, array_propagate_b, array_a_en, array_zero_in, c_valid, c_index
    );
endinterface

// File: rtl/ws_sta_ctrl.sv
// Weight-stationary array sequencer: LOAD_B -> STREAM -> DRAIN -> DONE; perf counters under WS_CTRL_PERF_EN.
// outputC valid LAT cycles after each A accept; b/a ready only in LOAD_B/STREAM, counters hold while valid=0.
module ws_sta_ctrl #(
    parameter int ROWS = 32,
    parameter int COLS = 32,
    parameter int LAT  = ROWS + COLS - 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] cfg_num_rows,
    output logic        busy,
    output logic        done,
    ws_sta_ctrl_if.slave bus
`ifdef WS_CTRL_PERF_EN
    ,
    output logic [31:0] perf_cycles,
    output logic [31:0] perf_stalls
`endif
);

    typedef enum logic [2:0] {IDLE, LOAD_B, STREAM, DRAIN, DONE} stateT;

    localparam logic [15:0] LAST_BEAT = 16'(ROWS - 1);

    stateT             state;
    stateT             nextState;
    logic [15:0]       mRows;
    logic [15:0]       beatCnt;
    logic [15:0]       aCnt;
    logic [15:0]       cIdx;
    logic [LAT-1:0]    tagSr;
    logic              aAccept;
    logic              startAccept;

    assign startAccept = (state == IDLE) && start;
    assign aAccept     = (state == STREAM) && bus.a_valid;

    always_comb begin
        nextState             = state;
        bus.b_ready           = 1'b0;
        bus.a_ready           = 1'b0;
        bus.array_propagate_b = 1'b0;
        bus.array_a_en        = 1'b0;
        bus.array_zero_in     = 1'b0;
        case (state)
            IDLE: begin
                if (start) nextState = LOAD_B;
            end
            LOAD_B: begin
                bus.b_ready           = 1'b1;
                bus.array_propagate_b = bus.b_valid;
                if (bus.b_valid && beatCnt == LAST_BEAT)
                    nextState = (mRows == 16'd0) ? DONE : STREAM;
            end
            STREAM: begin
                bus.a_ready       = 1'b1;
                bus.array_a_en    = 1'b1;
                bus.array_zero_in = !bus.a_valid;
                if (bus.a_valid && aCnt == mRows - 16'd1) nextState = DRAIN;
            end
            DRAIN: begin
                // Keep clocking zeros through so in-flight rows reach outputC.
                bus.array_a_en    = 1'b1;
                bus.array_zero_in = 1'b1;
                if (bus.c_valid && cIdx == mRows - 16'd1) nextState = DONE;
            end
            DONE: begin
                nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    assign busy        = (state != IDLE);
    assign done        = (state == DONE);
    assign bus.c_valid = tagSr[LAT-1];
    assign bus.c_index = cIdx;

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            mRows   <= 16'd0;
            beatCnt <= 16'd0;
            aCnt    <= 16'd0;
            cIdx    <= 16'd0;
            tagSr   <= '0;
        end else begin
            state <= nextState;
            tagSr <= (tagSr << 1) | LAT'(aAccept);
            if (startAccept) begin
                mRows   <= cfg_num_rows;
                beatCnt <= 16'd0;
                aCnt    <= 16'd0;
                cIdx    <= 16'd0;
            end else begin
                if (state == LOAD_B && bus.b_valid) beatCnt <= beatCnt + 16'd1;
                if (aAccept)                        aCnt    <= aCnt + 16'd1;
                if (bus.c_valid)                    cIdx    <= cIdx + 16'd1;
            end
        end
    end

`ifdef WS_CTRL_PERF_EN
    // The accepting IDLE cycle counts as cycle 1; values freeze once back in IDLE.
    always_ff @(posedge clock) begin
        if (reset) begin
            perf_cycles <= 32'd0;
            perf_stalls <= 32'd0;
        end else if (startAccept) begin
            perf_cycles <= 32'd1;
            perf_stalls <= 32'd0;
        end else if (state != IDLE) begin
            perf_cycles <= perf_cycles + 32'd1;
            if (state == STREAM && !bus.a_valid) perf_stalls <= perf_stalls + 32'd1;
        end
    end
`endif

endmodule
